// File: rtl/xm_mem_pkg.sv
// Shared types and encodings for the memory access unit and its lane steering.
package xm_mem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} mem_state_t;

   localparam logic [1:0] FLT_NONE    = 2'd0;
   localparam logic [1:0] FLT_ALIGN   = 2'd1;
   localparam logic [1:0] FLT_SIZE    = 2'd2;
   localparam logic [1:0] FLT_TIMEOUT = 2'd3;

   localparam logic [1:0] SZ_BYTE   = 2'd0;
   localparam logic [1:0] SZ_HALF   = 2'd1;
   localparam logic [1:0] SZ_WORD32 = 2'd2;
   localparam logic [1:0] SZ_WORD64 = 2'd3;

endpackage

// File: rtl/xm_lane_steer.sv
// Byte-lane steering: byte enables, store replication, load extract and extend.
// Purely combinational, no flow control.
module xm_lane_steer #(
   parameter int WORD = 16
) (
   input  logic [$clog2(WORD/8)-1:0] addr_lo,
   input  logic [1:0]                size,
   input  logic                      sext,
   input  logic [WORD-1:0]           wdata,
   input  logic [WORD-1:0]           rdata,
   output logic [WORD/8-1:0]         be,
   output logic [WORD-1:0]           wrep,
   output logic [WORD-1:0]           rext
);
   localparam int LANES = WORD / 8;

   always_comb begin
      int nb;
      int off;
      logic [WORD-1:0] sh;
      logic sbit;
      nb   = 1 << size;
      // Oversize requests fault upstream; clamp so the lane maths stays in range.
      if (nb > LANES) nb = LANES;
      off  = int'(addr_lo);
      sh   = rdata >> (8 * off);
      sbit = 1'b0;
      be   = '0;
      wrep = '0;
      rext = '0;
      for (int i = 0; i < LANES; i++) begin
         be[i] = (i >= off) && (i < off + nb);
         wrep[8*i +: 8] = 8'(wdata >> (8 * (i % nb)));
      end
      for (int j = 0; j < WORD; j++) begin
         if (j == 8 * nb - 1) sbit = sh[j];
      end
      for (int j = 0; j < WORD; j++) begin
         rext[j] = (j < 8 * nb) ? sh[j] : (sext & sbit);
      end
   end

endmodule

// File: rtl/xm_mem_access_unit.sv
// Single-outstanding load/store unit with alignment/size checks and ack timeout.
// Latency: req -> mem_req_o next cycle, done_o the cycle after ack; req_i ignored while busy_o.
module xm_mem_access_unit
   import xm_mem_pkg::*;
#(
   parameter int WORD    = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                             clk_i,
   input  logic                             arst_i,
   input  logic                             req_i,
   input  logic                             we_i,
   input  logic [1:0]                       size_i,
   input  logic                             sext_i,
   input  logic [WORD-1:0]                  addr_i,
   input  logic [WORD-1:0]                  wdata_i,
   output logic                             busy_o,
   output logic                             done_o,
   output logic [WORD-1:0]                  rdata_o,
   output logic                             fault_o,
   output logic [1:0]                       faultCode_o,
   output logic                             mem_req_o,
   output logic                             mem_we_o,
   output logic [WORD-$clog2(WORD/8)-1:0]   mem_adr_o,
   output logic [WORD/8-1:0]                mem_be_o,
   output logic [WORD-1:0]                  mem_wdat_o,
   input  logic [WORD-1:0]                  mem_rdat_i,
   input  logic                             mem_ack_i
);
   localparam int LANES = WORD / 8;
   localparam int LSB   = $clog2(LANES);
   localparam int CW    = $clog2(TIMEOUT + 1);

   mem_state_t       state, nxt;
   logic [LSB-1:0]   off_q;
   logic [1:0]       size_q;
   logic             sext_q, we_q;
   logic [CW-1:0]    cnt;
   logic [LSB-1:0]   amask;
   logic             size_bad, misalign, timeout_hit;
   logic [LANES-1:0] be;
   logic [WORD-1:0]  wrep, rext;

   assign size_bad    = (32'(1) << size_i) > 32'(LANES);
   assign amask       = LSB'((32'(1) << size_i) - 1);
   assign misalign    = |(addr_i[LSB-1:0] & amask);
   assign timeout_hit = (cnt == CW'(TIMEOUT));

   // Steering sees the live request when idle and the latched one during an access.
   xm_lane_steer #(.WORD(WORD)) u_steer (
      .addr_lo (busy_o ? off_q : addr_i[LSB-1:0]),
      .size    (busy_o ? size_q : size_i),
      .sext    (sext_q),
      .wdata   (wdata_i),
      .rdata   (mem_rdat_i),
      .be      (be),
      .wrep    (wrep),
      .rext    (rext)
   );

   always_comb begin
      nxt = state;
      case (state)
         ACCESS: begin
            if (mem_ack_i)        nxt = DONE;
            else if (timeout_hit) nxt = FAULT;
         end
         default: begin
            if (req_i) nxt = (size_bad || misalign) ? FAULT : ACCESS;
            else       nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state       <= IDLE;
         off_q       <= '0;
         size_q      <= '0;
         sext_q      <= 1'b0;
         we_q        <= 1'b0;
         cnt         <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         fault_o     <= 1'b0;
         rdata_o     <= '0;
         faultCode_o <= FLT_NONE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_adr_o   <= '0;
         mem_be_o    <= '0;
         mem_wdat_o  <= '0;
      end else begin
         state     <= nxt;
         busy_o    <= (nxt == ACCESS);
         mem_req_o <= (nxt == ACCESS);
         done_o    <= (nxt == DONE) || (nxt == FAULT);
         fault_o   <= (nxt == FAULT);
         if (state != ACCESS && req_i) begin
            off_q       <= addr_i[LSB-1:0];
            size_q      <= size_i;
            sext_q      <= sext_i;
            we_q        <= we_i;
            cnt         <= '0;
            faultCode_o <= size_bad ? FLT_SIZE : (misalign ? FLT_ALIGN : FLT_NONE);
            mem_adr_o   <= addr_i[WORD-1:LSB];
            mem_be_o    <= be;
            mem_wdat_o  <= wrep;
            mem_we_o    <= we_i & ~(size_bad | misalign);
         end
         if (state == ACCESS) begin
            if (mem_ack_i) begin
               if (!we_q) rdata_o <= rext;
            end else if (timeout_hit) begin
               faultCode_o <= FLT_TIMEOUT;
            end else begin
               cnt <= cnt + 1'b1;
            end
            if (nxt != ACCESS) mem_we_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xm_mem_access_unit.sv
// Directed checks of the memory access unit at WORD=16 and WORD=32, plus the lane steerer.
module tb_xm_mem_access_unit;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   // WORD=16, TIMEOUT=4 instance
   logic        req, we, sext, ack;
   logic [1:0]  size;
   logic [15:0] addr, wdata, rdat;
   logic        busy, done, fault, mreq, mwe;
   logic [1:0]  fcode, mbe;
   logic [15:0] rdata, mwdat;
   logic [14:0] madr;

   // WORD=32 instance
   logic        w_req, w_we, w_sext, w_ack;
   logic [1:0]  w_size;
   logic [31:0] w_addr, w_wdata, w_rdat;
   logic        w_busy, w_done, w_fault, w_mreq, w_mwe;
   logic [1:0]  w_fcode;
   logic [3:0]  w_mbe;
   logic [31:0] w_rdata, w_mwdat;
   logic [29:0] w_madr;

   // standalone steerer
   logic [1:0]  s_off, s_size;
   logic        s_sext;
   logic [31:0] s_wdata, s_rdata, s_wrep, s_rext;
   logic [3:0]  s_be;

   int nvec = 0;
   int nerr = 0;
   int hi;
   int dn;

   xm_mem_access_unit #(.WORD(16), .TIMEOUT(4)) dut16 (
      .clk_i(clk), .arst_i(arst), .req_i(req), .we_i(we), .size_i(size), .sext_i(sext),
      .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done), .rdata_o(rdata),
      .fault_o(fault), .faultCode_o(fcode), .mem_req_o(mreq), .mem_we_o(mwe),
      .mem_adr_o(madr), .mem_be_o(mbe), .mem_wdat_o(mwdat), .mem_rdat_i(rdat), .mem_ack_i(ack)
   );

   xm_mem_access_unit #(.WORD(32), .TIMEOUT(4)) dut32 (
      .clk_i(clk), .arst_i(arst), .req_i(w_req), .we_i(w_we), .size_i(w_size), .sext_i(w_sext),
      .addr_i(w_addr), .wdata_i(w_wdata), .busy_o(w_busy), .done_o(w_done), .rdata_o(w_rdata),
      .fault_o(w_fault), .faultCode_o(w_fcode), .mem_req_o(w_mreq), .mem_we_o(w_mwe),
      .mem_adr_o(w_madr), .mem_be_o(w_mbe), .mem_wdat_o(w_mwdat), .mem_rdat_i(w_rdat),
      .mem_ack_i(w_ack)
   );

   xm_lane_steer #(.WORD(32)) steer (
      .addr_lo(s_off), .size(s_size), .sext(s_sext), .wdata(s_wdata), .rdata(s_rdata),
      .be(s_be), .wrep(s_wrep), .rext(s_rext)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arst = 1'b0;
      req = 0; we = 0; sext = 0; ack = 0; size = 0; addr = 0; wdata = 0; rdat = 0;
      w_req = 0; w_we = 0; w_sext = 0; w_ack = 0; w_size = 0; w_addr = 0; w_wdata = 0; w_rdat = 0;
      s_off = 0; s_size = 0; s_sext = 0; s_wdata = 0; s_rdata = 0;
      tick(); tick();
      chk("reset16", 64'({busy, done, fault, mreq, mwe, fcode, rdata, mbe, madr, mwdat}), 64'h0);
      chk("reset32", 64'({w_busy, w_done, w_fault, w_mreq, w_fcode, w_rdata}), 64'h0);
      arst = 1'b1;
      tick();

      // word store, immediate ack
      req = 1; we = 1; size = 1; addr = 16'h0010; wdata = 16'hBEEF; ack = 1;
      tick(); req = 0;
      chk("st_req",  64'(mreq),  64'h1);
      chk("st_adr",  64'(madr),  64'h8);
      chk("st_be",   64'(mbe),   64'h3);
      chk("st_wdat", 64'(mwdat), 64'hBEEF);
      chk("st_we",   64'(mwe),   64'h1);
      chk("st_busy", 64'({busy, done}), 64'h2);
      tick();
      chk("st_done", 64'({done, fault, mreq, busy}), 64'h8);
      ack = 0;
      tick();
      chk("st_pulse", 64'(done), 64'h0);

      // byte load from lane 1, two wait cycles, sign-extended
      req = 1; we = 0; size = 0; sext = 1; addr = 16'h0003; rdat = 16'h80AA;
      tick(); req = 0;
      chk("ldb_be", 64'({mbe, mwe, mreq}), 64'h9);
      tick(); tick(); ack = 1; tick(); ack = 0;
      chk("ldb_sext", 64'(rdata), 64'hFF80);
      chk("ldb_done", 64'({done, fault}), 64'h2);
      tick();

      // same load, zero-extended
      req = 1; sext = 0;
      tick(); req = 0;
      tick(); tick(); ack = 1; tick(); ack = 0;
      chk("ldb_zext", 64'(rdata), 64'h0080);
      tick();

      // misaligned halfword load
      req = 1; size = 1; addr = 16'h0005;
      tick(); req = 0;
      chk("mis_req",  64'(mreq), 64'h0);
      chk("mis_done", 64'({done, fault}), 64'h3);
      chk("mis_code", 64'(fcode), 64'h1);
      tick();
      chk("mis_after", 64'({mreq, done, fcode}), 64'h1);

      // 32-bit access on a 16-bit bus
      req = 1; size = 2; addr = 16'h0000;
      tick(); req = 0;
      chk("sz_code", 64'(fcode), 64'h2);
      chk("sz_flt",  64'({done, fault, mreq}), 64'h6);
      tick();

      // store with no ack times out
      req = 1; we = 1; size = 1; addr = 16'h0020; wdata = 16'h1111;
      tick(); req = 0;
      hi = 0;
      for (int k = 0; k < 20 && mreq; k++) begin
         hi++;
         tick();
      end
      chk("to_len",   64'(hi), 64'd5);
      chk("to_flt",   64'({done, fault}), 64'h3);
      chk("to_code",  64'(fcode), 64'h3);
      chk("to_rdata", 64'(rdata), 64'h0080);
      tick();

      // ack in the last allowed cycle wins
      req = 1; we = 0; size = 1; sext = 0; addr = 16'h0000; rdat = 16'h1357;
      tick(); req = 0;
      repeat (4) tick();
      chk("to5_req", 64'(mreq), 64'h1);
      ack = 1; tick(); ack = 0;
      chk("to5_ok",    64'({done, fault}), 64'h2);
      chk("to5_code",  64'(fcode), 64'h0);
      chk("to5_rdata", 64'(rdata), 64'h1357);
      tick();

      // asynchronous reset mid-access
      req = 1; addr = 16'h0002;
      tick(); req = 0;
      chk("rst_pre", 64'(mreq), 64'h1);
      #2 arst = 1'b0;
      #1 chk("rst_async", 64'({busy, mreq, done, fault, fcode, rdata}), 64'h0);
      @(posedge clk); #1 arst = 1'b1;
      tick();

      // byte store, with requests issued while busy
      req = 1; we = 1; size = 0; addr = 16'h0011; wdata = 16'h005A;
      tick(); req = 0;
      chk("bs_be",   64'(mbe),   64'h2);
      chk("bs_wdat", 64'(mwdat), 64'h5A5A);
      dn = 0;
      req = 1; addr = 16'h0040; tick(); if (done) dn++;
      req = 0; tick(); if (done) dn++;
      req = 1; tick(); if (done) dn++;
      req = 0;
      chk("ig_adr", 64'(madr), 64'h8);
      ack = 1; tick(); if (done) dn++;
      ack = 0; tick(); if (done) dn++;
      tick(); if (done) dn++;
      chk("ig_done", 64'(dn), 64'd1);
      chk("ig_busy", 64'({busy, mreq}), 64'h0);

      // WORD=32 halfword store and byte load
      w_req = 1; w_we = 1; w_size = 1; w_addr = 32'h6; w_wdata = 32'h1234; w_ack = 1;
      tick(); w_req = 0;
      chk("w_be",   64'(w_mbe),   64'hC);
      chk("w_wdat", 64'(w_mwdat), 64'h12341234);
      chk("w_adr",  64'(w_madr),  64'h1);
      tick();
      chk("w_st_done", 64'({w_done, w_fault}), 64'h2);
      w_ack = 0; tick();
      w_req = 1; w_we = 0; w_size = 0; w_sext = 1; w_addr = 32'h5; w_rdat = 32'hAABBCCDD;
      tick(); w_req = 0;
      chk("w_ld_be", 64'(w_mbe), 64'h2);
      w_ack = 1; tick(); w_ack = 0;
      chk("w_rdata", 64'(w_rdata), 64'hFFFFFFCC);
      tick();

      // steerer on its own: upper halfword of a 32-bit bus
      s_off = 2'd2; s_size = 2'd1; s_sext = 1; s_wdata = 32'h0000ABCD; s_rdata = 32'h9A7B0000;
      #1;
      chk("s_be",   64'(s_be),   64'hC);
      chk("s_wrep", 64'(s_wrep), 64'hABCDABCD);
      chk("s_rext", 64'(s_rext), 64'hFFFF9A7B);
      s_sext = 0;
      #1;
      chk("s_zext", 64'(s_rext), 64'h00009A7B);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/xm_mem_access_unit.md
Name: xm_mem_access_unit

Overview:
- Parametrised load/store unit that replaces the fixed MAR/OMDR latching of the single-width multi-cycle datapath.
- Accepts one access request at a time from the control unit and checks alignment and size.
- Steers write data and byte enables onto a LANES-wide memory bus, waits for a variable-latency ack with a timeout, then extracts and zero/sign-extends read data.
- Sits between the datapath and the memory/MMIO fabric.

Parameters:
WORD, 16, datapath and memory bus width in bits; a power of two, at least 16.
TIMEOUT, 15, maximum cycles mem_req_o stays high without mem_ack_i before a timeout fault; at least 1.
LANES (localparam), WORD/8, number of byte lanes.
LSB (localparam), $clog2(LANES), number of byte-offset address bits.

Ports:
clk_i  in  1  system clock, rising edge.
arst_i  in  1  asynchronous reset, active-low.
req_i  in  1  access request; sampled only while busy_o=0.
we_i  in  1  1 = store, 0 = load.
size_i  in  2  log2 of access bytes: 0 = byte, 1 = 16b, 2 = 32b, 3 = 64b.
sext_i  in  1  sign-extend load result.
addr_i  in  WORD  byte address.
wdata_i  in  WORD  store data, right-aligned.
busy_o  out  1  a request is in flight.
done_o  out  1  one-cycle completion pulse (success or fault).
rdata_o  out  WORD  extended load result; holds until the next load completes.
fault_o  out  1  asserted with done_o when the access faulted.
faultCode_o  out  2  0 none, 1 misaligned, 2 size > WORD, 3 timeout; held until the next accepted request.
mem_req_o  out  1  memory request, held until ack or timeout.
mem_we_o  out  1  memory write strobe qualifier.
mem_adr_o  out  WORD-LSB  word address, addr_i[WORD-1:LSB].
mem_be_o  out  LANES  byte-lane enables.
mem_wdat_o  out  WORD  lane-replicated store data.
mem_rdat_i  in  WORD  memory read data, valid with ack.
mem_ack_i  in  1  access complete.

Behaviour:
- Reset (arst_i=0, asynchronous): state IDLE; all outputs 0, including rdata_o and faultCode_o. mem_req_o drops immediately, even mid-access.
- FSM states: IDLE, ACCESS, DONE, FAULT. All outputs are registered.
- IDLE, req_i=1 at edge N:
  - Latch addr_i, size_i, we_i, sext_i and wdata_i; clear faultCode_o; set busy_o at N+1.
  - If (1<<size_i) > LANES, go to FAULT with code 2.
  - Else if addr_i[size_i-1:0] != 0 (size_i > 0), go to FAULT with code 1.
  - Else go to ACCESS. At N+1 drive mem_req_o=1 with mem_adr_o, mem_be_o, mem_wdat_o and mem_we_o stable; clear the timeout counter.
- ACCESS:
  - mem_ack_i=1: capture the load result, go to DONE.
  - No ack: counter increments. When the counter reaches TIMEOUT with no ack, go to FAULT with code 3.
  - Ack in the same cycle the counter reaches TIMEOUT: the ack wins and the access succeeds.
- DONE: done_o=1, fault_o=0, busy_o drops, mem_req_o=0; return to IDLE.
- FAULT: done_o=1, fault_o=1, mem_req_o=0, busy_o drops; return to IDLE. Misaligned and size faults never raise mem_req_o.
- Minimum latency: req at edge N, mem_req_o at N+1, ack during N+1, done_o during N+2. A new req_i is accepted in the done_o cycle.
- req_i while busy_o=1 is ignored; there is no queueing.
- Byte enables: mem_be_o has (1<<size) ones starting at lane addr[LSB-1:0].
- Store data: mem_wdat_o is the low (8<<size) bits of wdata replicated across the bus, so each enabled lane carries its byte.
- Load data: bytes are taken from lane addr[LSB-1:0] upward, (8<<size) bits wide, then sign-extended (sext=1) or zero-extended (sext=0) to WORD. For a full-WORD access, extension is a no-op.
- A store leaves rdata_o unchanged.

Decomposition:
- Package xm_mem_pkg holds:
  - mem_state_t enum {IDLE, ACCESS, DONE, FAULT}.
  - Fault code constants FLT_NONE, FLT_ALIGN, FLT_SIZE, FLT_TIMEOUT.
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD32, SZ_WORD64.
- One combinational sub-module, xm_lane_steer (parameter WORD), performs byte-enable generation, write replication and read extract/extend. Both the unit and the bench reuse it.

Test Plan:
- Word store, WORD=16: addr 0x0010, wdata 0xBEEF, size 1, ack immediately -> mem_adr_o 0x0008, mem_be_o 2'b11, mem_wdat_o 0xBEEF, mem_we_o 1; done_o 2 cycles after req; fault_o 0.
- Byte load, sext: addr 0x0003, size 0, sext 1; memory returns 0x80AA after 2 wait cycles -> mem_be_o 2'b10, rdata_o 0xFF80. Repeat with sext 0 -> rdata_o 0x0080.
- Fault checks, WORD=16: misaligned word load at 0x0005 -> mem_req_o never high; done_o and fault_o high 1 cycle after req; faultCode_o 1. Size 2 request -> faultCode_o 2.
- Timeout, TIMEOUT=4, no ack -> mem_req_o high exactly 5 cycles, then drops; fault_o and done_o pulse; faultCode_o 3. Ack on the 5th cycle instead -> success, fault_o 0.
- Reset and ignored requests: arst_i low during ACCESS -> mem_req_o, busy_o and all outputs go to 0 asynchronously. After release, a new request completes normally. req_i pulses while busy_o=1 produce no extra done_o.
- WORD=32: halfword store 0x1234 at byte address 0x6 -> mem_be_o 4'b1100, mem_wdat_o 0x12341234; byte load at 0x5 with mem_rdat_i 0xAABBCCDD, sext 1 -> rdata_o 0xFFFFFFCC.
